axi_stream_strip_header: RTL and testbench



---
 rtl/axi_stream_strip_header_pkg.sv | 39 +++
 rtl/axi_stream_byte_merge.sv | 40 ++++
 rtl/axi_stream_strip_header.sv | 217 +++++++++++++++++++++
 tb/tb_axi_stream_strip_header.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_stream_strip_header_pkg.sv
// Shared definitions for the header insert/strip stream stages: byte width,
// FSM state encoding and keep/count conversion helpers.
package axi_stream_strip_header_pkg;

    localparam int unsigned BYTE_W    = 8;
    // Upper bound on bytes per beat handled by the keep helpers.
    localparam int unsigned MAX_BYTES = 64;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_FIRST  = 2'd1;
    localparam state_t ST_STREAM = 2'd2;
    localparam state_t ST_FLUSH  = 2'd3;

    // Number of valid bytes in an MSB-contiguous keep mask.
    function automatic int unsigned keep_to_cnt(input logic [MAX_BYTES-1:0] keep);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            cnt = cnt + 32'(keep[i]);
        end
        return cnt;
    endfunction

    // MSB-aligned mask of cnt ones inside an nbytes-wide keep field.
    function automatic logic [MAX_BYTES-1:0] cnt_to_keep(input int unsigned cnt,
                                                          input int unsigned nbytes);
        logic [MAX_BYTES-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            if ((i < nbytes) && ((i + cnt) >= nbytes)) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/axi_stream_byte_merge.sv
// Combinational merge of an MSB-aligned residue with an MSB-aligned input
// beat: produces one (possibly partial) output word plus the bytes left over.
module axi_stream_byte_merge
    import axi_stream_strip_header_pkg::*;
#(
    parameter int unsigned DATA_WD = 32,
    parameter int unsigned CNT_W   = $clog2(DATA_WD / 8) + 1
) (
    input  logic [DATA_WD-1:0] res_i,
    input  logic [CNT_W-1:0]   res_cnt_i,
    input  logic [DATA_WD-1:0] data_i,
    input  logic [CNT_W-1:0]   k_i,
    output logic [DATA_WD-1:0] merged_o,
    output logic [CNT_W-1:0]   merged_cnt_o,
    output logic [DATA_WD-1:0] leftover_o,
    output logic [CNT_W-1:0]   left_cnt_o
);

    localparam int unsigned NB    = DATA_WD / BYTE_W;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned SH    = $clog2(BYTE_W);

    logic [SUM_W-1:0] total_c;
    logic [CNT_W-1:0] take_c;

    // Input bytes fill the residue's free tail; whatever does not fit is leftover.
    always_comb begin
        total_c      = SUM_W'(res_cnt_i) + SUM_W'(k_i);
        take_c       = CNT_W'(NB) - res_cnt_i;
        merged_o     = res_i | (data_i >> {res_cnt_i, {SH{1'b0}}});
        leftover_o   = data_i << {take_c, {SH{1'b0}}};
        merged_cnt_o = CNT_W'(total_c);
        left_cnt_o   = '0;
        if (total_c >= SUM_W'(NB)) begin
            merged_cnt_o = CNT_W'(NB);
            left_cnt_o   = CNT_W'(total_c - SUM_W'(NB));
        end
    end

endmodule

// File: rtl/axi_stream_strip_header.sv
// Strips N leading header bytes from each AXI-Stream packet and re-aligns the
// payload to full MSB-first beats. Optional header capture port is enabled by
// defining AXIS_STRIP_HDR_CAPTURE_EN; otherwise hdr outputs are tied to zero.
module axi_stream_strip_header
    import axi_stream_strip_header_pkg::*;
#(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid_in,
    input  logic [DATA_WD-1:0]        data_in,
    input  logic [DATA_BYTE_WD-1:0]   keep_in,
    input  logic                      last_in,
    output logic                      ready_in,
    output logic                      valid_out,
    output logic [DATA_WD-1:0]        data_out,
    output logic [DATA_BYTE_WD-1:0]   keep_out,
    output logic                      last_out,
    input  logic                      ready_out,
    input  logic                      valid_strip,
    input  logic [BYTE_CNT_WD:0]      byte_strip_cnt,
    output logic                      ready_strip,
    output logic                      hdr_valid_out,
    output logic [DATA_WD-1:0]        hdr_data_out
);

    localparam int unsigned CNT_W = BYTE_CNT_WD + 1;
    localparam int unsigned SH    = $clog2(BYTE_W);
    localparam logic [DATA_WD-1:0] ALL_ONES = '1;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    n_q, n_d;
    logic [DATA_WD-1:0]  res_q, res_d;
    logic [CNT_W-1:0]    res_cnt_q, res_cnt_d;

    logic                valid_q, valid_d;
    logic [DATA_WD-1:0]  data_q, data_d;
    logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
    logic                last_q, last_d;

    logic                out_free_c;
    logic                in_hs_c;
    logic                first_hs_c;
    logic [CNT_W-1:0]    k_c;
    logic [DATA_WD-1:0]  data_m_c;
    logic [DATA_WD-1:0]  first_res_c;
    logic [CNT_W-1:0]    first_cnt_c;

    logic [DATA_WD-1:0]  merged_c;
    logic [CNT_W-1:0]    merged_cnt_c;
    logic [DATA_WD-1:0]  leftover_c;
    logic [CNT_W-1:0]    left_cnt_c;

    // Handshake qualifiers and first-beat split (header bytes shifted out).
    assign out_free_c  = !valid_q || ready_out;
    assign ready_in    = ((state_q == ST_FIRST) || (state_q == ST_STREAM)) && out_free_c;
    assign ready_strip = (state_q == ST_IDLE);
    assign in_hs_c     = valid_in && ready_in;
    assign first_hs_c  = in_hs_c && (state_q == ST_FIRST);
    assign k_c         = CNT_W'(keep_to_cnt(MAX_BYTES'(keep_in)));
    assign data_m_c    = data_in & ~(ALL_ONES >> {k_c, {SH{1'b0}}});
    assign first_res_c = data_m_c << {n_q, {SH{1'b0}}};
    assign first_cnt_c = k_c - n_q;

    axi_stream_byte_merge #(
        .DATA_WD (DATA_WD),
        .CNT_W   (CNT_W)
    ) u_merge (
        .res_i        (res_q),
        .res_cnt_i    (res_cnt_q),
        .data_i       (data_m_c),
        .k_i          (k_c),
        .merged_o     (merged_c),
        .merged_cnt_o (merged_cnt_c),
        .leftover_o   (leftover_c),
        .left_cnt_o   (left_cnt_c)
    );

    // Next-state: FSM, residue and the single output register.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        res_d     = res_q;
        res_cnt_d = res_cnt_q;
        valid_d   = valid_q && !ready_out;
        data_d    = data_q;
        keep_d    = keep_q;
        last_d    = last_q;

        case (state_q)
            ST_IDLE: begin
                if (valid_strip) begin
                    n_d     = byte_strip_cnt;
                    state_d = ST_FIRST;
                end
            end
            ST_FIRST: begin
                if (first_hs_c) begin
                    // A full first beat (N=0) or a last beat goes straight out.
                    if (last_in || (first_cnt_c == CNT_W'(DATA_BYTE_WD))) begin
                        if (first_cnt_c != '0) begin
                            valid_d = 1'b1;
                            data_d  = first_res_c;
                            keep_d  = DATA_BYTE_WD'(cnt_to_keep(32'(first_cnt_c), DATA_BYTE_WD));
                            last_d  = last_in;
                        end
                        res_d     = '0;
                        res_cnt_d = '0;
                        state_d   = last_in ? ST_IDLE : ST_STREAM;
                    end else begin
                        res_d     = first_res_c;
                        res_cnt_d = first_cnt_c;
                        state_d   = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                if (in_hs_c) begin
                    valid_d   = 1'b1;
                    data_d    = merged_c;
                    keep_d    = DATA_BYTE_WD'(cnt_to_keep(32'(merged_cnt_c), DATA_BYTE_WD));
                    last_d    = 1'b0;
                    res_d     = leftover_c;
                    res_cnt_d = left_cnt_c;
                    if (last_in) begin
                        if (left_cnt_c != '0) begin
                            state_d = ST_FLUSH;
                        end else begin
                            last_d    = 1'b1;
                            res_d     = '0;
                            state_d   = ST_IDLE;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (out_free_c) begin
                    valid_d   = 1'b1;
                    data_d    = res_q;
                    keep_d    = DATA_BYTE_WD'(cnt_to_keep(32'(res_cnt_q), DATA_BYTE_WD));
                    last_d    = 1'b1;
                    res_d     = '0;
                    res_cnt_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            n_q       <= '0;
            res_q     <= '0;
            res_cnt_q <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            keep_q    <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            res_q     <= res_d;
            res_cnt_q <= res_cnt_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            keep_q    <= keep_d;
            last_q    <= last_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign keep_out  = keep_q;
    assign last_out  = last_q;

`ifdef AXIS_STRIP_HDR_CAPTURE_EN
    logic               hdr_valid_q, hdr_valid_d;
    logic [DATA_WD-1:0] hdr_data_q, hdr_data_d;
    logic [DATA_WD-1:0] hdr_c;

    assign hdr_c = data_m_c & ~(ALL_ONES >> {n_q, {SH{1'b0}}});

    // Capture header bytes on the first-beat handshake; pulse valid once.
    always_comb begin
        hdr_valid_d = 1'b0;
        hdr_data_d  = hdr_data_q;
        if (first_hs_c) begin
            hdr_valid_d = 1'b1;
            hdr_data_d  = hdr_c;
        end
    end

    // Header capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_valid_q <= 1'b0;
            hdr_data_q  <= '0;
        end else begin
            hdr_valid_q <= hdr_valid_d;
            hdr_data_q  <= hdr_data_d;
        end
    end

    assign hdr_valid_out = hdr_valid_q;
    assign hdr_data_out  = hdr_data_q;
`else
    assign hdr_valid_out = 1'b0;
    assign hdr_data_out  = '0;
`endif

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Directed bench for axi_stream_strip_header (DATA_WD=32).
module tb_axi_stream_strip_header;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        last_in;
    logic        ready_in;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_out;
    logic        valid_strip;
    logic [2:0]  byte_strip_cnt;
    logic        ready_strip;
    logic        hdr_valid_out;
    logic [31:0] hdr_data_out;

    int checks   = 0;
    int failures = 0;

    logic [31:0] q_data[$];
    logic [3:0]  q_keep[$];
    logic        q_last[$];
    int          hdr_seen = 0;
    logic [31:0] hdr_last = '0;

    axi_stream_strip_header #(.DATA_WD(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .data_in        (data_in),
        .keep_in        (keep_in),
        .last_in        (last_in),
        .ready_in       (ready_in),
        .valid_out      (valid_out),
        .data_out       (data_out),
        .keep_out       (keep_out),
        .last_out       (last_out),
        .ready_out      (ready_out),
        .valid_strip    (valid_strip),
        .byte_strip_cnt (byte_strip_cnt),
        .ready_strip    (ready_strip),
        .hdr_valid_out  (hdr_valid_out),
        .hdr_data_out   (hdr_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output beats accepted on the coming edge, plus header pulses.
    always @(negedge clk) begin
        if (rst_n && valid_out && ready_out) begin
            q_data.push_back(data_out);
            q_keep.push_back(keep_out);
            q_last.push_back(last_out);
        end
        if (hdr_valid_out) begin
            hdr_seen = hdr_seen + 1;
            hdr_last = hdr_data_out;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ready_strip"}, 64'(ready_strip), 64'd1);
        chk({tag, "_ready_in"},    64'(ready_in),    64'd0);
        chk({tag, "_valid_out"},   64'(valid_out),   64'd0);
        chk({tag, "_last_out"},    64'(last_out),    64'd0);
        chk({tag, "_keep_out"},    64'(keep_out),    64'd0);
        chk({tag, "_data_out"},    64'(data_out),    64'd0);
        chk({tag, "_hdr_valid"},   64'(hdr_valid_out), 64'd0);
        chk({tag, "_hdr_data"},    64'(hdr_data_out),  64'd0);
    endtask

    task automatic clear_q();
        q_data.delete();
        q_keep.delete();
        q_last.delete();
    endtask

    task automatic check_beat(input string tag, input int idx, input logic [31:0] d,
                              input logic [3:0] k, input logic l);
        logic [31:0] od;
        logic [3:0]  ok;
        logic        ol;
        od = 'x; ok = 'x; ol = 1'bx;
        if (idx < q_data.size()) begin
            od = q_data[idx];
            ok = q_keep[idx];
            ol = q_last[idx];
        end
        chk({tag, "_data"}, 64'(od), 64'(d));
        chk({tag, "_keep"}, 64'(ok), 64'(k));
        chk({tag, "_last"}, 64'(ol), 64'(l));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0] n, input string tag);
        logic hs;
        hs = 1'b0;
        valid_strip    = 1'b1;
        byte_strip_cnt = n;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk);
            hs = ready_strip;
            @(posedge clk);
            #1;
        end
        valid_strip = 1'b0;
        chk({tag, "_cmd_hs"}, 64'(hs), 64'd1);
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                              input string tag);
        logic hs;
        hs = 1'b0;
        valid_in = 1'b1;
        data_in  = d;
        keep_in  = k;
        last_in  = l;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk);
            hs = ready_in;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        last_in  = 1'b0;
        chk({tag, "_hs"}, 64'(hs), 64'd1);
    endtask

    initial begin
        rst_n          = 1'b0;
        valid_in       = 1'b0;
        data_in        = '0;
        keep_in        = '0;
        last_in        = 1'b0;
        ready_out      = 1'b1;
        valid_strip    = 1'b0;
        byte_strip_cnt = '0;

        repeat (2) @(posedge clk);
        #1;
        check_reset("rst");
        rst_n = 1'b1;
        idle(1);

        // N=2: three-beat packet, tail merges into a final full beat
        clear_q();
        send_cmd(3'd2, "t1");
        drive_beat(32'hAABB1122, 4'b1111, 1'b0, "t1_b0");
        drive_beat(32'h33445566, 4'b1111, 1'b0, "t1_b1");
        drive_beat(32'h77880000, 4'b1100, 1'b1, "t1_b2");
        idle(3);
        chk("t1_count", 64'(q_data.size()), 64'd2);
        check_beat("t1_o0", 0, 32'h11223344, 4'b1111, 1'b0);
        check_beat("t1_o1", 1, 32'h55667788, 4'b1111, 1'b1);
        chk("t1_ready_strip", 64'(ready_strip), 64'd1);
`ifdef AXIS_STRIP_HDR_CAPTURE_EN
        chk("t1_hdr", 64'(hdr_last), 64'hAABB0000);
        chk("t1_hdr_pulses", 64'(hdr_seen), 64'd1);
`else
        chk("t1_hdr", 64'(hdr_data_out), 64'd0);
        chk("t1_hdr_pulses", 64'(hdr_seen), 64'd0);
`endif

        // N=3: leftover byte forces a FLUSH beat
        clear_q();
        send_cmd(3'd3, "t2");
        drive_beat(32'hA1A2A311, 4'b1111, 1'b0, "t2_b0");
        drive_beat(32'h22334455, 4'b1111, 1'b1, "t2_b1");
        idle(4);
        chk("t2_count", 64'(q_data.size()), 64'd2);
        check_beat("t2_o0", 0, 32'h11223344, 4'b1111, 1'b0);
        check_beat("t2_o1", 1, 32'h55000000, 4'b1000, 1'b1);
`ifdef AXIS_STRIP_HDR_CAPTURE_EN
        chk("t2_hdr", 64'(hdr_last), 64'hA1A2A300);
`endif

        // N=0: pass-through with one-cycle latency
        clear_q();
        send_cmd(3'd0, "t3");
        drive_beat(32'h01020304, 4'b1111, 1'b0, "t3_b0");
        chk("t3_lat_valid", 64'(valid_out), 64'd1);
        chk("t3_lat_data",  64'(data_out),  64'h01020304);
        drive_beat(32'h05060708, 4'b1111, 1'b0, "t3_b1");
        drive_beat(32'h090A0B00, 4'b1110, 1'b1, "t3_b2");
        idle(3);
        chk("t3_count", 64'(q_data.size()), 64'd3);
        check_beat("t3_o0", 0, 32'h01020304, 4'b1111, 1'b0);
        check_beat("t3_o1", 1, 32'h05060708, 4'b1111, 1'b0);
        check_beat("t3_o2", 2, 32'h090A0B00, 4'b1110, 1'b1);

        // N=4: single-beat packet is consumed entirely by the header
        clear_q();
        send_cmd(3'd4, "t4");
        drive_beat(32'hDEADBEEF, 4'b1111, 1'b1, "t4_b0");
        chk("t4_ready_strip", 64'(ready_strip), 64'd1);
        chk("t4_valid_out",   64'(valid_out),   64'd0);
`ifdef AXIS_STRIP_HDR_CAPTURE_EN
        chk("t4_hdr_valid", 64'(hdr_valid_out), 64'd1);
        chk("t4_hdr_data",  64'(hdr_data_out),  64'hDEADBEEF);
`else
        chk("t4_hdr_valid", 64'(hdr_valid_out), 64'd0);
        chk("t4_hdr_data",  64'(hdr_data_out),  64'd0);
`endif
        idle(3);
        chk("t4_count", 64'(q_data.size()), 64'd0);

        // N=1 with downstream stall for two cycles
        clear_q();
        send_cmd(3'd1, "t5");
        drive_beat(32'hC0112233, 4'b1111, 1'b0, "t5_b0");
        drive_beat(32'h44556677, 4'b1111, 1'b0, "t5_b1");
        ready_out = 1'b0;
        valid_in  = 1'b1;
        data_in   = 32'h8899AABB;
        keep_in   = 4'b1111;
        last_in   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t5_stall_ready_in", 64'(ready_in),  64'd0);
            chk("t5_stall_valid",    64'(valid_out), 64'd1);
            chk("t5_stall_data",     64'(data_out),  64'h11223344);
            @(posedge clk);
            #1;
        end
        ready_out = 1'b1;
        drive_beat(32'h8899AABB, 4'b1111, 1'b1, "t5_b2");
        idle(4);
        chk("t5_count", 64'(q_data.size()), 64'd3);
        check_beat("t5_o0", 0, 32'h11223344, 4'b1111, 1'b0);
        check_beat("t5_o1", 1, 32'h55667788, 4'b1111, 1'b0);
        check_beat("t5_o2", 2, 32'h99AABB00, 4'b1110, 1'b1);

        // Reset in the middle of STREAM, then a fresh N=2 packet
        clear_q();
        send_cmd(3'd2, "t6");
        drive_beat(32'hAABB0102, 4'b1111, 1'b0, "t6_b0");
        drive_beat(32'h03040506, 4'b1111, 1'b0, "t6_b1");
        chk("t6_pre_valid", 64'(valid_out), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset("t6_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_q();
        idle(1);
        send_cmd(3'd2, "t6n");
        drive_beat(32'hAABBCCDD, 4'b1111, 1'b0, "t6n_b0");
        drive_beat(32'hEEFF0011, 4'b1000, 1'b1, "t6n_b1");
        idle(3);
        chk("t6n_count", 64'(q_data.size()), 64'd1);
        check_beat("t6n_o0", 0, 32'hCCDDEE00, 4'b1110, 1'b1);
        chk("t6n_ready_strip", 64'(ready_strip), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
